mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequential front end between `cpu` and the single-port synchronous `dbg_mem`.
- Replaces the combinational pc/load address mux and the derived memory clock.
- Takes three request/acknowledge channels from the CPU (instruction fetch, load, store) and serialises them onto one memory port. Memory runs on the common `clk` with a configurable read latency.
- Returns read data with a one-cycle acknowledge pulse, so multicycle CPU states wait on ack instead of clock gating.

Parameters:
- W, `WORD_WIDTH (32): data and address width.
- LAT, 1: memory read latency in cycles, counted from the edge that samples `mem_en`; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high until `if_ack`.
- if_addr  input  W  fetch address (pc).
- if_ack  output  1  one-cycle pulse; `if_data` valid.
- if_data  output  W  fetched instruction; holds until the next read ack.
- ld_req  input  1  load request; held until `ld_ack`.
- ld_addr  input  W  load address.
- ld_ack  output  1  one-cycle pulse; `ld_data` valid.
- ld_data  output  W  load data; holds until the next read ack.
- st_req  input  1  store request; held until `st_ack`.
- st_addr  input  W  store address.
- st_data  input  W  store data.
- st_ack  output  1  one-cycle pulse; write issued.
- mem_en  output  1  memory access strobe, registered.
- mem_we  output  1  write enable, registered; only high together with `mem_en`.
- mem_addr  output  W  word-aligned address, registered.
- mem_wdata  output  W  write data, registered.
- mem_rdata  input  W  memory read data.
- busy  output  1  high in any state other than IDLE.
- misalign  output  1  one-cycle pulse in ACCESS when the granted address has [1:0] != 0.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state = IDLE.
  - All acks, `mem_en`, `mem_we`, `misalign` and `busy` = 0.
  - `mem_addr`, `mem_wdata`, `if_data` and `ld_data` = 0.
  - LAT counter = 0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Fixed-priority grant: store > load > fetch, sampling the req levels in this cycle.
  - On grant, at the next edge: latch address with [1:0] forced to 0, latch write data and the channel id, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (1 cycle):
  - `mem_en`=1; `mem_we`=1 only for a store.
  - Store: next state DONE.
  - Read: next state WAIT, counter loaded with LAT.
- WAIT (LAT cycles):
  - Counter decrements each cycle.
  - On the edge that ends the cycle where the counter = 1, capture `mem_rdata` into `if_data` or `ld_data` per channel id, then go to DONE.
- DONE (1 cycle):
  - Ack of the granted channel = 1; other acks stay 0.
  - Next state IDLE unconditionally.
- Latency, from the first IDLE cycle with req high to the ack cycle:
  - Store: 2 cycles.
  - Read: LAT+2 cycles (3 for LAT=1).
- Requester rules:
  - The requester samples ack at the edge ending DONE and drops req by the following IDLE cycle.
  - If req is still high in IDLE, a new transaction starts; back-to-back transactions are legal.
  - A request that is dropped before its grant is never served.
  - A request that is dropped after its grant still completes, including the write and the ack.
- Simultaneous requests: only one is granted per IDLE visit; the losers stay pending without starvation guarantees. Fetch and load are never concurrent in the multicycle CPU.
- Data hold: `if_data` and `ld_data` change only on their own capture edge.
- Reset during ACCESS: a write sampled by memory in that cycle may complete; no ack is issued.
- Reset during WAIT: captured data is discarded.
- Address width: W bits passed through; no wrap logic; bits [1:0] are always 0 on `mem_addr`.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs `cnt_if`, `cnt_ld`, `cnt_st` and `cnt_stall`, each 32 bits.
  - `cnt_if`, `cnt_ld` and `cnt_st` increment in the DONE cycle of their channel.
  - `cnt_stall` increments in every IDLE cycle where more than one req is high.
  - All counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- In defines.v: `WORD_WIDTH`; state encodings `ARB_IDLE`/`ARB_ACCESS`/`ARB_WAIT`/`ARB_DONE` (2-bit); channel ids `CH_IF`/`CH_LD`/`CH_ST` (2-bit).
- Sub-module `arb_prio_sel`: combinational fixed-priority encoder. Inputs: the three reqs. Outputs: a grant valid flag and the channel id.

Test Plan:
- Reset, then `if_req`=1 with `if_addr`=0x0000_0010 and memory word[4]=0x2408_0005, LAT=1 -> `mem_en` high in cycle 1 with `mem_addr`=0x10; `if_ack` in cycle 3; `if_data`=0x2408_0005.
- `st_req`, `st_addr`=0x40, `st_data`=0xDEAD_BEEF -> `mem_we`=`mem_en`=1 in cycle 1; `st_ack` in cycle 2. A subsequent load from 0x40 returns 0xDEAD_BEEF with `ld_ack` in cycle 3 of that load.
- `st_req` and `ld_req` raised in the same cycle -> store granted first, load granted in the IDLE cycle after `st_ack`; `cnt_stall`=1 with MEM_ARB_STATS_EN.
- LAT=3, load from 0x8 -> `ld_ack` exactly 5 cycles after req; `ld_data` is unchanged during WAIT.
- Load from `ld_addr`=0x13 -> `misalign` pulse in ACCESS, `mem_addr`=0x10, data from word 0x10 returned.
- `rst` low during WAIT of a fetch -> all outputs 0 immediately, no `if_ack`; after release, `if_req` still high restarts the fetch and completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: word width, FSM state
// encodings, channel ids and the read-latency counter width.
package mem_port_arbiter_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int LAT_MIN    = 1;
  localparam int LAT_MAX    = 15;
  localparam int LAT_CNT_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    CH_NONE = 2'd0,
    CH_IF   = 2'd1,
    CH_LD   = 2'd2,
    CH_ST   = 2'd3
  } arb_ch_e;

  // Fetch and load both read memory; only the store channel writes.
  function automatic logic ch_is_read(arb_ch_e ch);
    return (ch == CH_IF) || (ch == CH_LD);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// Fixed-priority request encoder for the memory port arbiter: store beats load
// beats fetch. Purely combinational.
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
(
  input  logic    if_req,
  input  logic    ld_req,
  input  logic    st_req,
  output logic    grant_valid,
  output arb_ch_e grant_ch
);

  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = CH_NONE;
    if (st_req) begin
      grant_valid = 1'b1;
      grant_ch    = CH_ST;
    end else if (ld_req) begin
      grant_valid = 1'b1;
      grant_ch    = CH_LD;
    end else if (if_req) begin
      grant_valid = 1'b1;
      grant_ch    = CH_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU fetch/load/store requests onto one synchronous single-port memory
// with a configurable read latency. Define MEM_ARB_STATS_EN for traffic counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W   = WORD_WIDTH,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_req,
  input  logic [W-1:0] if_addr,
  output logic         if_ack,
  output logic [W-1:0] if_data,
  input  logic         ld_req,
  input  logic [W-1:0] ld_addr,
  output logic         ld_ack,
  output logic [W-1:0] ld_data,
  input  logic         st_req,
  input  logic [W-1:0] st_addr,
  input  logic [W-1:0] st_data,
  output logic         st_ack,
  output logic         mem_en,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  output logic         busy,
  output logic         misalign
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]  cnt_if,
  output logic [31:0]  cnt_ld,
  output logic [31:0]  cnt_st,
  output logic [31:0]  cnt_stall
`endif
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LAT);
  localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);

  arb_state_e           state_q, state_d;
  arb_ch_e              ch_q;
  arb_ch_e              grant_ch;
  logic                 grant_valid;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 lat_last;
  logic [1:0]           addr_lo_q;
  logic [W-1:0]         sel_addr;

  arb_prio_sel u_prio_sel (
    .if_req      (if_req),
    .ld_req      (ld_req),
    .st_req      (st_req),
    .grant_valid (grant_valid),
    .grant_ch    (grant_ch)
  );

  always_comb begin
    sel_addr = if_addr;
    case (grant_ch)
      CH_ST:   sel_addr = st_addr;
      CH_LD:   sel_addr = ld_addr;
      default: sel_addr = if_addr;
    endcase
  end

  // A counter of 0 in WAIT can only follow an illegal LAT; treat it as the last cycle.
  assign lat_last = (lat_cnt <= LAT_ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (grant_valid) state_d = ARB_ACCESS;
      ARB_ACCESS: state_d = ch_is_read(ch_q) ? ARB_WAIT : ARB_DONE;
      ARB_WAIT:   if (lat_last) state_d = ARB_DONE;
      ARB_DONE:   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // The memory strobe is raised on the grant edge so it is high exactly in ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q      <= CH_NONE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_lo_q <= 2'b00;
      lat_cnt   <= '0;
      if_data   <= '0;
      ld_data   <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant_valid) begin
            ch_q      <= grant_ch;
            mem_en    <= 1'b1;
            mem_we    <= (grant_ch == CH_ST);
            mem_addr  <= {sel_addr[W-1:2], 2'b00};
            addr_lo_q <= sel_addr[1:0];
            if (grant_ch == CH_ST) mem_wdata <= st_data;
          end
        end
        ARB_ACCESS: begin
          if (ch_is_read(ch_q)) lat_cnt <= LAT_INIT;
        end
        ARB_WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_ONE;
          if (lat_last) begin
            if (ch_q == CH_IF)      if_data <= mem_rdata;
            else if (ch_q == CH_LD) ld_data <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if_ack = 1'b0;
    ld_ack = 1'b0;
    st_ack = 1'b0;
    if (state_q == ARB_DONE) begin
      case (ch_q)
        CH_IF:   if_ack = 1'b1;
        CH_LD:   ld_ack = 1'b1;
        CH_ST:   st_ack = 1'b1;
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != ARB_IDLE);
  assign misalign = (state_q == ARB_ACCESS) && (addr_lo_q != 2'b00);

`ifdef MEM_ARB_STATS_EN
  logic multi_req;

  assign multi_req = (if_req & ld_req) | (if_req & st_req) | (ld_req & st_req);

  // Completion counters tick on the edge ending DONE; stall counts contended IDLE cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_if    <= '0;
      cnt_ld    <= '0;
      cnt_st    <= '0;
      cnt_stall <= '0;
    end else begin
      if (state_q == ARB_DONE) begin
        case (ch_q)
          CH_IF:   cnt_if <= cnt_if + 32'd1;
          CH_LD:   cnt_ld <= cnt_ld + 32'd1;
          CH_ST:   cnt_st <= cnt_st + 32'd1;
          default: ;
        endcase
      end
      if ((state_q == ARB_IDLE) && multi_req) cnt_stall <= cnt_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LAT=1 instance driven from a vector table and
// hand sequences, plus a LAT=3 instance for the long-latency load cases.
module tb_mem_port_arbiter;

  localparam logic [1:0] OP_IF = 2'd1;
  localparam logic [1:0] OP_LD = 2'd2;
  localparam logic [1:0] OP_ST = 2'd3;
  localparam int TIMEOUT = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        if_req = 1'b0, ld_req = 1'b0, st_req = 1'b0;
  logic [31:0] if_addr = '0, ld_addr = '0, st_addr = '0, st_data = '0;
  logic        if_ack, ld_ack, st_ack, mem_en, mem_we, busy, misalign;
  logic [31:0] if_data, ld_data, mem_addr, mem_wdata, mem_rdata;

  logic        ld_req_3 = 1'b0;
  logic [31:0] ld_addr_3 = '0;
  logic        if_ack_3, ld_ack_3, st_ack_3, mem_en_3, mem_we_3, busy_3, misalign_3;
  logic [31:0] if_data_3, ld_data_3, mem_addr_3, mem_wdata_3, mem_rdata_3;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] cnt_if, cnt_ld, cnt_st, cnt_stall;
  logic [31:0] cnt_if_3, cnt_ld_3, cnt_st_3, cnt_stall_3;
`endif

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.W(32), .LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .misalign(misalign)
`ifdef MEM_ARB_STATS_EN
    , .cnt_if(cnt_if), .cnt_ld(cnt_ld), .cnt_st(cnt_st), .cnt_stall(cnt_stall)
`endif
  );

  mem_port_arbiter #(.W(32), .LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(32'h0), .if_ack(if_ack_3), .if_data(if_data_3),
    .ld_req(ld_req_3), .ld_addr(ld_addr_3), .ld_ack(ld_ack_3), .ld_data(ld_data_3),
    .st_req(1'b0), .st_addr(32'h0), .st_data(32'h0), .st_ack(st_ack_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3), .misalign(misalign_3)
`ifdef MEM_ARB_STATS_EN
    , .cnt_if(cnt_if_3), .cnt_ld(cnt_ld_3), .cnt_st(cnt_st_3), .cnt_stall(cnt_stall_3)
`endif
  );

  // Memory models: outside the valid read slot the data bus carries a poison value.
  logic [31:0] mem1 [0:255];
  logic [31:0] rd1 = 32'hBAD0_0001;
  always @(posedge clk) begin
    if (!rst) begin
      mem1[4]   <= 32'h2408_0005;
      mem1[255] <= 32'hCAFE_F00D;
      rd1       <= 32'hBAD0_0001;
    end else if (mem_en && mem_we) begin
      mem1[mem_addr[9:2]] <= mem_wdata;
      rd1 <= 32'hBAD0_0001;
    end else if (mem_en) begin
      rd1 <= mem1[mem_addr[9:2]];
    end else begin
      rd1 <= 32'hBAD0_0001;
    end
  end
  assign mem_rdata = rd1;

  logic [31:0] mem3 [0:255];
  logic [31:0] rd3 [0:2];
  always @(posedge clk) begin
    if (!rst) begin
      mem3[2] <= 32'h0BAD_CAFE;
      mem3[3] <= 32'h7777_1111;
    end else if (mem_en_3 && mem_we_3) begin
      mem3[mem_addr_3[9:2]] <= mem_wdata_3;
    end
    rd3[0] <= (mem_en_3 && !mem_we_3) ? mem3[mem_addr_3[9:2]] : 32'hBAD0_0003;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign mem_rdata_3 = rd3[2];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_lat;
    logic        exp_mis;
    bit          drop_early;
  } vec_t;

  vec_t vecs [0:8];

  int          obs_lat, obs_en_cyc, obs_ack_ch;
  logic [31:0] obs_addr;
  logic        obs_we, obs_mis;
  int          obs_lat3, hold_bad3;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request on the LAT=1 instance and record what happens until its ack.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit drop_early);
    obs_lat = -1; obs_en_cyc = -1; obs_ack_ch = 0;
    obs_addr = '0; obs_we = 1'b0; obs_mis = 1'b0;
    @(negedge clk);
    case (op)
      OP_IF:   begin if_addr = addr; if_req = 1'b1; end
      OP_LD:   begin ld_addr = addr; ld_req = 1'b1; end
      default: begin st_addr = addr; st_data = wdata; st_req = 1'b1; end
    endcase
    for (int cyc = 0; cyc <= TIMEOUT; cyc++) begin
      if (mem_en && obs_en_cyc < 0) begin
        obs_en_cyc = cyc; obs_addr = mem_addr; obs_we = mem_we; obs_mis = misalign;
      end
      if (if_ack || ld_ack || st_ack) begin
        obs_lat = cyc;
        case ({if_ack, ld_ack, st_ack})
          3'b100:  obs_ack_ch = 1;
          3'b010:  obs_ack_ch = 2;
          3'b001:  obs_ack_ch = 3;
          default: obs_ack_ch = 7;
        endcase
        break;
      end
      if (drop_early && cyc == 1) begin
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
      end
      @(negedge clk);
    end
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
  endtask

  // Load on the LAT=3 instance; ld_data_3 must not move before the ack cycle.
  task automatic run_ld3(input logic [31:0] addr);
    logic [31:0] prev;
    prev = ld_data_3;
    obs_lat3 = -1; hold_bad3 = 0;
    @(negedge clk);
    ld_addr_3 = addr; ld_req_3 = 1'b1;
    for (int cyc = 0; cyc <= TIMEOUT; cyc++) begin
      if (ld_ack_3) begin obs_lat3 = cyc; break; end
      if (ld_data_3 !== prev) hold_bad3++;
      @(negedge clk);
    end
    ld_req_3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int st_cyc, ld_cyc, busy_seen, rcyc;
    logic [31:0] save_if, save_ld;

    vecs[0] = '{OP_IF, 32'h0000_0010, 32'h0,         32'h0000_0010, 32'h2408_0005, 3, 1'b0, 1'b0};
    vecs[1] = '{OP_ST, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0040, 32'h0,         2, 1'b0, 1'b0};
    vecs[2] = '{OP_LD, 32'h0000_0040, 32'h0,         32'h0000_0040, 32'hDEAD_BEEF, 3, 1'b0, 1'b0};
    vecs[3] = '{OP_LD, 32'h0000_0013, 32'h0,         32'h0000_0010, 32'h2408_0005, 3, 1'b1, 1'b0};
    vecs[4] = '{OP_ST, 32'h0000_0022, 32'h1234_5678, 32'h0000_0020, 32'h0,         2, 1'b1, 1'b1};
    vecs[5] = '{OP_IF, 32'h0000_0021, 32'h0,         32'h0000_0020, 32'h1234_5678, 3, 1'b1, 1'b0};
    vecs[6] = '{OP_LD, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 32'hCAFE_F00D, 3, 1'b0, 1'b0};
    vecs[7] = '{OP_ST, 32'h0000_0040, 32'h0,         32'h0000_0040, 32'h0,         2, 1'b0, 1'b0};
    vecs[8] = '{OP_LD, 32'h0000_0040, 32'h0,         32'h0000_0040, 32'h0,         3, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check_output("rst_ctrl", 64'({if_ack, ld_ack, st_ack, mem_en, mem_we, busy, misalign}), 64'h0);
    check_output("rst_mem_addr", 64'(mem_addr), 64'h0);
    check_output("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    check_output("rst_data", {if_data, ld_data}, 64'h0);
    check_output("rst_lat3", 64'({if_ack_3, ld_ack_3, st_ack_3, mem_en_3, mem_we_3, busy_3, misalign_3}), 64'h0);
    check_output("rst_lat3_data", {if_data_3, mem_wdata_3}, 64'h0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      save_if = if_data; save_ld = ld_data;
      apply_stimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].drop_early);
      check_output($sformatf("v%0d_lat", i), 64'(obs_lat), 64'(vecs[i].exp_lat));
      check_output($sformatf("v%0d_en_cyc", i), 64'(obs_en_cyc), 64'd1);
      check_output($sformatf("v%0d_mem_addr", i), 64'(obs_addr), 64'(vecs[i].exp_addr));
      check_output($sformatf("v%0d_mem_we", i), 64'(obs_we), 64'(vecs[i].op == OP_ST));
      check_output($sformatf("v%0d_misalign", i), 64'(obs_mis), 64'(vecs[i].exp_mis));
      check_output($sformatf("v%0d_ack_ch", i), 64'(obs_ack_ch), 64'(vecs[i].op));
      if (vecs[i].op == OP_IF) begin
        check_output($sformatf("v%0d_if_data", i), 64'(if_data), 64'(vecs[i].exp_data));
        check_output($sformatf("v%0d_ld_hold", i), 64'(ld_data), 64'(save_ld));
      end else if (vecs[i].op == OP_LD) begin
        check_output($sformatf("v%0d_ld_data", i), 64'(ld_data), 64'(vecs[i].exp_data));
        check_output($sformatf("v%0d_if_hold", i), 64'(if_data), 64'(save_if));
      end else begin
        check_output($sformatf("v%0d_data_hold", i), {if_data, ld_data}, {save_if, save_ld});
      end
    end

    // Store and load raised together: store first, load in the IDLE after st_ack.
    st_cyc = -1; ld_cyc = -1;
    @(negedge clk);
    st_addr = 32'h44; st_data = 32'h5555_AAAA; st_req = 1'b1;
    ld_addr = 32'h44; ld_req = 1'b1;
    for (int cyc = 0; cyc <= TIMEOUT; cyc++) begin
      if (st_ack) begin st_cyc = cyc; st_req = 1'b0; end
      if (ld_ack) begin ld_cyc = cyc; break; end
      @(negedge clk);
    end
    st_req = 1'b0; ld_req = 1'b0;
    check_output("pair_st_ack_cyc", 64'(st_cyc), 64'd2);
    check_output("pair_ld_ack_cyc", 64'(ld_cyc), 64'd6);
    check_output("pair_ld_data", 64'(ld_data), 64'h5555_AAAA);

    // A request pulse that never sees a clock edge must not be served.
    busy_seen = 0;
    @(negedge clk);
    if_addr = 32'h10; if_req = 1'b1;
    #1 if_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy || mem_en) busy_seen++;
    end
    check_output("dropped_req_idle", 64'(busy_seen), 64'd0);

`ifdef MEM_ARB_STATS_EN
    check_output("cnt_stall", 64'(cnt_stall), 64'd1);
    check_output("cnt_if", 64'(cnt_if), 64'd2);
    check_output("cnt_ld", 64'(cnt_ld), 64'd5);
    check_output("cnt_st", 64'(cnt_st), 64'd4);
`endif

    // Reset in WAIT of a fetch, then the still-pending fetch restarts.
    @(negedge clk);
    if_addr = 32'h10; if_req = 1'b1;
    repeat (2) @(negedge clk);
    check_output("wait_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check_output("wrst_ctrl", 64'({if_ack, ld_ack, st_ack, mem_en, mem_we, busy, misalign}), 64'h0);
    check_output("wrst_data", {if_data, ld_data}, 64'h0);
    check_output("wrst_mem_addr", 64'(mem_addr), 64'h0);
    @(negedge clk);
    check_output("wrst_no_ack", 64'({if_ack, busy}), 64'h0);
    rst = 1'b1;
    rcyc = -1;
    for (int cyc = 0; cyc <= TIMEOUT; cyc++) begin
      if (if_ack) begin rcyc = cyc; break; end
      @(negedge clk);
    end
    if_req = 1'b0;
    check_output("restart_ack_cyc", 64'(rcyc), 64'd3);
    check_output("restart_if_data", 64'(if_data), 64'h2408_0005);

    // LAT=3: ack five cycles after req, ld_data frozen until capture.
    run_ld3(32'h8);
    check_output("lat3_ack_cyc", 64'(obs_lat3), 64'd5);
    check_output("lat3_data", 64'(ld_data_3), 64'h0BAD_CAFE);
    check_output("lat3_hold", 64'(hold_bad3), 64'd0);
    run_ld3(32'hC);
    check_output("lat3b_ack_cyc", 64'(obs_lat3), 64'd5);
    check_output("lat3b_data", 64'(ld_data_3), 64'h7777_1111);
    check_output("lat3b_hold", 64'(hold_bad3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
